// File: rtl/iter_alu.sv
// Iterative execute-stage ALU: single-cycle arithmetic/logic ops and bit-serial
// shifts, with the registered result returned over a valid/ready handshake.
module iter_alu #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [3:0]      i_alu_sel,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    input  logic            i_flush,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_zero
);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [1:0] SH_SLL = 2'd0;
    localparam logic [1:0] SH_SRL = 2'd1;
    localparam logic [1:0] SH_SRA = 2'd2;

    localparam logic [SHW-1:0] CNT_ZERO = {SHW{1'b0}};
    localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};

    function automatic logic [XLEN-1:0] shift1(input logic [XLEN-1:0] v, input logic [1:0] kind);
        logic [XLEN-1:0] r;
        case (kind)
            SH_SLL:  r = {v[XLEN-2:0], 1'b0};
            SH_SRL:  r = {1'b0, v[XLEN-1:1]};
            SH_SRA:  r = {v[XLEN-1], v[XLEN-1:1]};
            default: r = v;
        endcase
        return r;
    endfunction

    function automatic logic is_zero(input logic [XLEN-1:0] v);
        return (v == {XLEN{1'b0}});
    endfunction

    logic [1:0]      r_state;
    logic            r_out_valid;
    logic [XLEN-1:0] r_result;
    logic            r_zero;
    logic [XLEN-1:0] r_acc;
    logic [SHW-1:0]  r_cnt;
    logic [1:0]      r_sh_kind;

    logic [1:0]      w_state_nxt;
    logic [XLEN-1:0] w_res_nxt;
    logic            w_zero_nxt;
    logic [XLEN-1:0] w_acc_nxt;
    logic [SHW-1:0]  w_cnt_nxt;
    logic [1:0]      w_kind_nxt;

    logic [XLEN-1:0] w_alu_res;
    logic            w_is_shift;
    logic [1:0]      w_sh_kind;
    logic [SHW-1:0]  w_shamt;
    logic            w_lt_s;
    logic            w_lt_u;
    logic [XLEN-1:0] w_a_step;
    logic [XLEN-1:0] w_acc_step;

    assign w_shamt    = i_op_b[SHW-1:0];
    assign w_lt_s     = ($signed(i_op_a) < $signed(i_op_b));
    assign w_lt_u     = (i_op_a < i_op_b);
    assign w_a_step   = shift1(i_op_a, w_sh_kind);
    assign w_acc_step = shift1(r_acc, r_sh_kind);

    assign o_in_ready  = (r_state == ST_IDLE) & ~i_flush;
    assign o_out_valid = r_out_valid;
    assign o_result    = r_result;
    assign o_zero      = r_zero;

    // Decode the request: single-cycle result or shift kind.
    always_comb begin
        w_alu_res  = {XLEN{1'b0}};
        w_is_shift = 1'b0;
        w_sh_kind  = SH_SLL;
        case (i_alu_sel)
            ALU_ADD:  w_alu_res = i_op_a + i_op_b;
            ALU_SUB:  w_alu_res = i_op_a - i_op_b;
            ALU_AND:  w_alu_res = i_op_a & i_op_b;
            ALU_OR:   w_alu_res = i_op_a | i_op_b;
            ALU_XOR:  w_alu_res = i_op_a ^ i_op_b;
            ALU_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, w_lt_s};
            ALU_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, w_lt_u};
            ALU_SLL: begin
                w_is_shift = 1'b1;
                w_sh_kind  = SH_SLL;
            end
            ALU_SRL: begin
                w_is_shift = 1'b1;
                w_sh_kind  = SH_SRL;
            end
            ALU_SRA: begin
                w_is_shift = 1'b1;
                w_sh_kind  = SH_SRA;
            end
            default:  w_alu_res = {XLEN{1'b0}};
        endcase
    end

    // Next-state logic. The first shift bit is taken on the accept edge itself,
    // so a shift by n becomes visible n cycles after accept.
    always_comb begin
        w_state_nxt = r_state;
        w_res_nxt   = r_result;
        w_zero_nxt  = r_zero;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_kind_nxt  = r_sh_kind;
        if (i_flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_in_valid) begin
                        if (w_is_shift) begin
                            w_kind_nxt = w_sh_kind;
                            if (w_shamt == CNT_ZERO) begin
                                w_acc_nxt   = i_op_a;
                                w_cnt_nxt   = CNT_ZERO;
                                w_res_nxt   = i_op_a;
                                w_zero_nxt  = is_zero(i_op_a);
                                w_state_nxt = ST_DONE;
                            end else if (w_shamt == CNT_ONE) begin
                                w_acc_nxt   = w_a_step;
                                w_cnt_nxt   = CNT_ZERO;
                                w_res_nxt   = w_a_step;
                                w_zero_nxt  = is_zero(w_a_step);
                                w_state_nxt = ST_DONE;
                            end else begin
                                w_acc_nxt   = w_a_step;
                                w_cnt_nxt   = w_shamt - CNT_ONE;
                                w_state_nxt = ST_SHIFT;
                            end
                        end else begin
                            w_res_nxt   = w_alu_res;
                            w_zero_nxt  = is_zero(w_alu_res);
                            w_state_nxt = ST_DONE;
                        end
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    w_acc_nxt = w_acc_step;
                    w_cnt_nxt = r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        w_res_nxt   = w_acc_step;
                        w_zero_nxt  = is_zero(w_acc_step);
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    if (i_out_ready) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= {XLEN{1'b0}};
            r_zero      <= 1'b1;
            r_acc       <= {XLEN{1'b0}};
            r_cnt       <= CNT_ZERO;
            r_sh_kind   <= SH_SLL;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt == ST_DONE);
            r_result    <= w_res_nxt;
            r_zero      <= w_zero_nxt;
            r_acc       <= w_acc_nxt;
            r_cnt       <= w_cnt_nxt;
            r_sh_kind   <= w_kind_nxt;
        end
    end

endmodule

// File: tb/tb_iter_alu.sv
// Directed self-checking bench for iter_alu: op results, latency, backpressure,
// flush and mid-operation reset.
module tb_iter_alu;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_sel;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    iter_alu #(.XLEN(32)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_alu_sel   (alu_sel),
        .i_op_a      (op_a),
        .i_op_b      (op_b),
        .i_flush     (flush),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_result    (result),
        .o_zero      (zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, measure latency, check result, then complete the handshake.
    task automatic run_op(input string tag, input logic [3:0] sel, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_lat, input bit poke);
        int lat;
        bit rdy_bad;
        check({tag, "/ready_before"}, {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        alu_sel   = sel;
        op_a      = a;
        op_b      = b;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        alu_sel  = ALU_ADD;
        op_a     = 32'hDEAD_BEEF;
        op_b     = 32'h1234_5678;
        lat      = 1;
        rdy_bad  = 1'b0;
        while (!out_valid && lat < 40) begin
            if (in_ready) rdy_bad = 1'b1;
            in_valid = poke & lat[0];
            tick();
            lat++;
        end
        in_valid = 1'b0;
        check({tag, "/latency"}, lat, exp_lat);
        check({tag, "/result"}, result, exp_res);
        check({tag, "/zero"}, {31'd0, zero}, {31'd0, (exp_res == 32'd0)});
        check({tag, "/ready_low_busy"}, {31'd0, rdy_bad}, 32'd0);
        tick();
        check({tag, "/valid_after_hs"}, {31'd0, out_valid}, 32'd0);
        check({tag, "/ready_after_hs"}, {31'd0, in_ready}, 32'd1);
    endtask

    // Start an SRL by 20 and let it run into its fifth SHIFT cycle.
    task automatic start_long_shift(output bit early_valid);
        check("long/ready_before", {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        alu_sel   = ALU_SRL;
        op_a      = 32'hFFFF_FFFF;
        op_b      = 32'd20;
        out_ready = 1'b1;
        tick();
        in_valid    = 1'b0;
        early_valid = out_valid;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (out_valid) early_valid = 1'b1;
        end
    endtask

    task automatic watch_idle(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check({tag, "/no_valid"}, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        bit bad;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        alu_sel   = 4'd0;
        op_a      = 32'd0;
        op_b      = 32'd0;
        flush     = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check("reset/out_valid", {31'd0, out_valid}, 32'd0);
        check("reset/result", result, 32'd0);
        check("reset/zero", {31'd0, zero}, 32'd1);
        rst_n = 1'b1;
        #1;
        check("reset/in_ready", {31'd0, in_ready}, 32'd1);

        run_op("add_ovf",  ALU_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1, 1'b0);
        run_op("sub_zero", ALU_SUB,  32'd5,         32'd5,         32'h0000_0000, 1, 1'b0);
        run_op("slt",      ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1, 1'b0);
        run_op("sltu",     ALU_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 1'b0);
        run_op("undef",    4'hF,     32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 1, 1'b0);
        run_op("or",       ALU_OR,   32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1, 1'b0);
        run_op("xor",      ALU_XOR,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1, 1'b0);
        run_op("sll_by1",  ALU_SLL,  32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 1, 1'b0);
        run_op("sll_by0",  ALU_SLL,  32'h0000_1234, 32'h0000_0020, 32'h0000_1234, 1, 1'b0);
        run_op("srl_by4",  ALU_SRL,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 4, 1'b0);
        run_op("sra_by4",  ALU_SRA,  32'h8000_0010, 32'h0000_0004, 32'hF800_0001, 4, 1'b0);
        run_op("sra_by31", ALU_SRA,  32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 31, 1'b1);

        // Backpressure: hold DONE for 10 cycles with out_ready low.
        in_valid  = 1'b1;
        alu_sel   = ALU_AND;
        op_a      = 32'hFF00_FF00;
        op_b      = 32'h0F0F_0F0F;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        check("bp/valid", {31'd0, out_valid}, 32'd1);
        check("bp/result", result, 32'h0F00_0F00);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!out_valid || in_ready || result !== 32'h0F00_0F00) bad = 1'b1;
        end
        check("bp/held_stable", {31'd0, bad}, 32'd0);
        out_ready = 1'b1;
        tick();
        check("bp/valid_after_hs", {31'd0, out_valid}, 32'd0);
        check("bp/ready_after_hs", {31'd0, in_ready}, 32'd1);
        check("bp/result_kept", result, 32'h0F00_0F00);

        // Flush and out_ready together in DONE: flush wins, result held.
        in_valid  = 1'b1;
        alu_sel   = ALU_OR;
        op_a      = 32'h0000_0003;
        op_b      = 32'h0000_0004;
        out_ready = 1'b0;
        tick();
        in_valid  = 1'b0;
        flush     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("flush_done/ready_during_flush", {31'd0, in_ready}, 32'd0);
        tick();
        flush = 1'b0;
        #1;
        check("flush_done/valid", {31'd0, out_valid}, 32'd0);
        check("flush_done/ready", {31'd0, in_ready}, 32'd1);
        check("flush_done/result_kept", result, 32'h0000_0007);

        // Flush in the middle of a long shift.
        start_long_shift(bad);
        check("flush_shift/no_early_valid", {31'd0, bad}, 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        check("flush_shift/valid", {31'd0, out_valid}, 32'd0);
        check("flush_shift/ready", {31'd0, in_ready}, 32'd1);
        check("flush_shift/result_kept", result, 32'h0000_0007);
        check("flush_shift/zero_kept", {31'd0, zero}, 32'd0);
        watch_idle("flush_shift");
        run_op("add_after_flush", ALU_ADD, 32'd2, 32'd3, 32'd5, 1, 1'b0);

        // Reset in the middle of a long shift.
        start_long_shift(bad);
        check("rst_shift/no_early_valid", {31'd0, bad}, 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check("rst_shift/valid", {31'd0, out_valid}, 32'd0);
        check("rst_shift/ready", {31'd0, in_ready}, 32'd1);
        check("rst_shift/result", result, 32'd0);
        check("rst_shift/zero", {31'd0, zero}, 32'd1);
        watch_idle("rst_shift");
        run_op("add_after_rst", ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
